button_debouncer: RTL and testbench
===================================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 240_000, is the number of stable cycles required to accept an edge (20 ms at 12 MHz); legal range >= 2.
REQ-002 Parameter LONG_CYCLES, default 12_000_000, is the number of cycles after an accepted press at which a long press is flagged (1 s at 12 MHz); legal range >= 2.
REQ-003 Parameter ACTIVE_HIGH, default 1, selects the pressed level of BTN_IN: 1 means high = pressed, 0 means low = pressed.
REQ-004 The block SHALL use exactly one clock, CLK, and its reset SHALL be asynchronous and active-low, named RST_N.
REQ-005 CLK  input  1  system clock (12 MHz).
REQ-006 RST_N  input  1  asynchronous active-low reset.
REQ-007 BTN_IN  input  1  raw, asynchronous, bouncing pushbutton.
REQ-008 BTN_LEVEL  output  1  debounced level, 1 = pressed, registered.
REQ-009 PRESS_PULSE  output  1  one-cycle strobe on an accepted press, registered.
REQ-010 RELEASE_PULSE  output  1  one-cycle strobe on an accepted release, registered.
REQ-011 LONG_PULSE  output  1  one-cycle strobe, issued once per press that is held for LONG_CYCLES.

Function
REQ-012 BTN_IN SHALL pass through a 2-flop synchronizer; only the second stage (sync2, normalized to 1 = pressed) drives the FSM.
REQ-013 The FSM SHALL have states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, with one shared counter of width ceil(log2(max(DEBOUNCE_CYCLES, LONG_CYCLES))).
REQ-014 IDLE: if sync2 = 1, the FSM SHALL go to PRESS_WAIT and clear the counter; otherwise it stays in IDLE.
REQ-015 PRESS_WAIT: if sync2 = 0, the FSM SHALL return to IDLE and clear the counter, with no pulse. This rule has priority over the terminal count.
REQ-016 PRESS_WAIT: if sync2 = 1 and the counter = DEBOUNCE_CYCLES-1, the FSM SHALL go to PRESSED, clear the counter, set BTN_LEVEL = 1 and pulse PRESS_PULSE; otherwise the counter increments.
REQ-017 PRESSED: if sync2 = 0, the FSM SHALL go to RELEASE_WAIT and clear the counter.
REQ-018 PRESSED with sync2 = 1 and the long_done flag clear: at counter = LONG_CYCLES-1 the block SHALL pulse LONG_PULSE and set long_done; otherwise the counter increments.
REQ-019 PRESSED with long_done set: the counter SHALL hold, and no further LONG_PULSE is issued for that press.
REQ-020 RELEASE_WAIT: if sync2 = 1, the FSM SHALL return to PRESSED with the counter cleared and long_done unchanged, with no pulse. This rule has priority over the terminal count.
REQ-021 RELEASE_WAIT: if sync2 = 0 and the counter = DEBOUNCE_CYCLES-1, the FSM SHALL go to IDLE, clear the counter and long_done, set BTN_LEVEL = 0 and pulse RELEASE_PULSE; otherwise the counter increments.
REQ-022 Latency: if BTN_IN is first sampled pressed at edge E0 and stays pressed, PRESS_PULSE and BTN_LEVEL SHALL go high after edge E0+DEBOUNCE_CYCLES+2.
REQ-023 Latency: LONG_PULSE SHALL go high after edge E0+DEBOUNCE_CYCLES+2+LONG_CYCLES.
REQ-024 Latency: release SHALL be symmetric, with RELEASE_PULSE high after edge R0+DEBOUNCE_CYCLES+2.
REQ-025 Each pulse SHALL be high for exactly one cycle, and at most one of PRESS_PULSE, RELEASE_PULSE and LONG_PULSE SHALL be high in any cycle.
REQ-026 The counter SHALL never wrap; it is cleared only on the transitions listed above.
REQ-027 BTN_LEVEL SHALL be directly usable as an active-high reset/clear input of the downstream LED counter.

Reset
REQ-028 While RST_N = 0, the block SHALL immediately (asynchronously) force all outputs to 0, state to IDLE, the counter to 0 and long_done to 0.
REQ-029 While RST_N = 0, both synchronizer flops SHALL be forced to the released level, which is !ACTIVE_HIGH.
REQ-030 After RST_N rises with the button held, the block SHALL treat the press as new, issuing PRESS_PULSE DEBOUNCE_CYCLES+2 edges after the first edge that samples it pressed.
REQ-031 Reset asserted in PRESS_WAIT or RELEASE_WAIT SHALL abort that wait with no pulse.

Verification (DEBOUNCE_CYCLES = 4, LONG_CYCLES = 10, ACTIVE_HIGH = 1)
REQ-032 Clean press held 8 cycles from E0 -> PRESS_PULSE = 1 only after E6, and BTN_LEVEL = 1 from E6.
REQ-033 Bounce: BTN_IN = 1 for 3 edges, then 0 for 3 edges, repeated 4 times -> no pulses, and BTN_LEVEL stays 0.
REQ-034 Hold 20 cycles from E0 -> PRESS_PULSE after E6, LONG_PULSE once after E16, and no second LONG_PULSE.
REQ-035 Release at R0 after an accepted press, with one 2-cycle re-press glitch at R0+2 -> RELEASE_PULSE exactly once, 6 edges after the final clean release, and no extra PRESS_PULSE.
REQ-036 RST_N pulled low at E0+4 during PRESS_WAIT, then released with BTN_IN still 1 -> outputs 0 at once, then PRESS_PULSE 6 edges after the first post-reset sample.
REQ-037 ACTIVE_HIGH = 0, BTN_IN idle high, driven low for 8 cycles -> same timing as REQ-032, and no pulse out of reset.

Source files
------------

// File: rtl/button_debouncer_if.sv
// Pushbutton-side signal bundle for button_debouncer: raw button in, debounced level and strobes out.
// The debouncer takes the master view; whatever consumes the button events takes the slave view.
interface button_debouncer_if;
  logic BTN_IN;
  logic BTN_LEVEL;
  logic PRESS_PULSE;
  logic RELEASE_PULSE;
  logic LONG_PULSE;

  modport master (
    input  BTN_IN,
    output BTN_LEVEL,
    output PRESS_PULSE,
    output RELEASE_PULSE,
    output LONG_PULSE
  );

  modport slave (
    output BTN_IN,
    input  BTN_LEVEL,
    input  PRESS_PULSE,
    input  RELEASE_PULSE,
    input  LONG_PULSE
  );
endinterface

// File: rtl/button_debouncer.sv
// Debounces a raw pushbutton into a registered level plus press, release and long-press strobes.
// A single counter is shared between the debounce waits and the long-press timer.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 240_000,
  parameter int LONG_CYCLES     = 12_000_000,
  parameter bit ACTIVE_HIGH     = 1'b1
) (
  input logic CLK,
  input logic RST_N,
  button_debouncer_if.master btn
);

  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES);

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  logic          sync1;
  logic          sync2;
  logic          pressed_now;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          long_done;
  logic          btn_level;
  logic          press_pulse;
  logic          release_pulse;
  logic          long_pulse;

  // Reset parks the synchronizer at the released level so no phantom press follows reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= ~ACTIVE_HIGH;
      sync2 <= ~ACTIVE_HIGH;
    end else begin
      sync1 <= btn.BTN_IN;
      sync2 <= sync1;
    end
  end

  assign pressed_now = (sync2 == ACTIVE_HIGH);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      long_done     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pressed_now) begin
            state <= ST_PRESS_WAIT;
            cnt   <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!pressed_now) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state       <= ST_PRESSED;
            cnt         <= '0;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        // Once the long press has fired the counter freezes, so it can never wrap while held.
        ST_PRESSED: begin
          if (!pressed_now) begin
            state <= ST_RELEASE_WAIT;
            cnt   <= '0;
          end else if (!long_done) begin
            if (cnt == LONG_LAST) begin
              long_pulse <= 1'b1;
              long_done  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        ST_RELEASE_WAIT: begin
          if (pressed_now) begin
            state <= ST_PRESSED;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            long_done     <= 1'b0;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign btn.BTN_LEVEL     = btn_level;
  assign btn.PRESS_PULSE   = press_pulse;
  assign btn.RELEASE_PULSE = release_pulse;
  assign btn.LONG_PULSE    = long_pulse;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: an active-high and an active-low instance see the same button and are
// compared every cycle against a run-length model of the debounce rules, plus directed latency checks.
module tb_button_debouncer;

  localparam int DEB  = 4;
  localparam int LONG = 10;

  logic CLK   = 1'b0;
  logic RST_N = 1'b1;

  button_debouncer_if if_ah1 ();
  button_debouncer_if if_ah0 ();

  button_debouncer #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .ACTIVE_HIGH(1'b1)) dut_ah1 (
    .CLK(CLK), .RST_N(RST_N), .btn(if_ah1)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .ACTIVE_HIGH(1'b0)) dut_ah0 (
    .CLK(CLK), .RST_N(RST_N), .btn(if_ah0)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int edge_num = 0;

  // Model state: two-sample input delay, current run lengths of pressed/released samples.
  bit m_d1, m_d2, m_level, m_incl, m_long_done, m_press, m_release, m_long;
  int m_run1, m_run0;

  int press_count, release_count, long_count, level_seen;
  int press_edge, release_edge, long_edge, press_edge_ah0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t observed=%0h expected=%0h", tag, $time, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_d1 = 0; m_d2 = 0; m_level = 0; m_incl = 0; m_long_done = 0;
    m_press = 0; m_release = 0; m_long = 0; m_run1 = 0; m_run0 = 0;
  endtask

  // A press is accepted once DEB+1 consecutive pressed samples reach the FSM; a long press fires LONG
  // samples after the streak that entered the pressed state (acceptance or a bounce back from release).
  task automatic modelStep(input bit raw_pressed);
    bit s;
    s = m_d2; m_d2 = m_d1; m_d1 = raw_pressed;
    m_press = 0; m_release = 0; m_long = 0;
    if (s) begin m_run1++; m_run0 = 0; end
    else begin m_run0++; m_run1 = 0; m_incl = 0; end
    if (!m_level && m_run1 == DEB + 1) begin
      m_level = 1; m_press = 1; m_incl = 1; m_long_done = 0;
    end else if (m_level && m_run0 == DEB + 1) begin
      m_level = 0; m_release = 1; m_long_done = 0;
    end else if (m_level && s && !m_long_done && m_run1 == (m_incl ? DEB + 1 + LONG : LONG + 1)) begin
      m_long = 1; m_long_done = 1;
    end
  endtask

  function automatic logic [31:0] packOut(input logic l, input logic p, input logic r, input logic g);
    return {28'd0, l, p, r, g};
  endfunction

  task automatic clearTally();
    press_count = 0; release_count = 0; long_count = 0; level_seen = 0;
    press_edge = -1; release_edge = -1; long_edge = -1; press_edge_ah0 = -1;
  endtask

  // Called at a negedge; holds the button at the given level for the given number of edges.
  task automatic applyStimulus(input bit pressed, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if_ah1.BTN_IN = pressed;
      if_ah0.BTN_IN = ~pressed;
      @(posedge CLK);
      edge_num++;
      modelStep(pressed);
      @(negedge CLK);
      checkOutput("ah1_outputs", packOut(if_ah1.BTN_LEVEL, if_ah1.PRESS_PULSE, if_ah1.RELEASE_PULSE, if_ah1.LONG_PULSE),
                  packOut(m_level, m_press, m_release, m_long));
      checkOutput("ah0_outputs", packOut(if_ah0.BTN_LEVEL, if_ah0.PRESS_PULSE, if_ah0.RELEASE_PULSE, if_ah0.LONG_PULSE),
                  packOut(m_level, m_press, m_release, m_long));
      if (if_ah1.PRESS_PULSE)   begin press_count++;   press_edge = edge_num;   end
      if (if_ah1.RELEASE_PULSE) begin release_count++; release_edge = edge_num; end
      if (if_ah1.LONG_PULSE)    begin long_count++;    long_edge = edge_num;    end
      if (if_ah1.BTN_LEVEL)     level_seen++;
      if (if_ah0.PRESS_PULSE)   press_edge_ah0 = edge_num;
    end
  endtask

  // Asserts reset away from a clock edge and checks that outputs clear before any edge arrives.
  task automatic doReset(input int cycles);
    #2;
    RST_N = 1'b0;
    #1;
    modelReset();
    checkOutput("reset_async_ah1", packOut(if_ah1.BTN_LEVEL, if_ah1.PRESS_PULSE, if_ah1.RELEASE_PULSE, if_ah1.LONG_PULSE), 32'd0);
    checkOutput("reset_async_ah0", packOut(if_ah0.BTN_LEVEL, if_ah0.PRESS_PULSE, if_ah0.RELEASE_PULSE, if_ah0.LONG_PULSE), 32'd0);
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLK);
      edge_num++;
      @(negedge CLK);
      checkOutput("reset_hold", packOut(if_ah1.BTN_LEVEL, if_ah1.PRESS_PULSE, if_ah1.RELEASE_PULSE, if_ah1.LONG_PULSE), 32'd0);
    end
    RST_N = 1'b1;
  endtask

  initial begin
    int e0, r0;
    bit lvl;
    if_ah1.BTN_IN = 1'b0;
    if_ah0.BTN_IN = 1'b1;
    modelReset();
    clearTally();
    #2;
    doReset(3);
    applyStimulus(0, 5);

    // Clean press held 8 edges, then clean release.
    clearTally();
    e0 = edge_num + 1;
    applyStimulus(1, 8);
    checkOutput("clean_press_latency", press_edge - e0, 6);
    checkOutput("clean_press_latency_ah0", press_edge_ah0 - e0, 6);
    checkOutput("clean_press_count", press_count, 1);
    r0 = edge_num + 1;
    applyStimulus(0, 10);
    checkOutput("clean_release_latency", release_edge - r0, 6);

    // Bounce 3-on/3-off four times must never be accepted.
    clearTally();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 3);
      applyStimulus(0, 3);
    end
    applyStimulus(0, 6);
    checkOutput("bounce_press_count", press_count, 0);
    checkOutput("bounce_release_count", release_count, 0);
    checkOutput("bounce_level_seen", level_seen, 0);

    // Long hold: one long pulse only.
    clearTally();
    e0 = edge_num + 1;
    applyStimulus(1, 20);
    checkOutput("hold_press_latency", press_edge - e0, 6);
    checkOutput("hold_long_latency", long_edge - e0, 16);
    applyStimulus(1, 12);
    checkOutput("hold_long_count", long_count, 1);

    // Release with a 2-cycle re-press glitch at R0+2.
    clearTally();
    r0 = edge_num + 1;
    applyStimulus(0, 2);
    applyStimulus(1, 2);
    applyStimulus(0, 10);
    checkOutput("glitch_release_count", release_count, 1);
    checkOutput("glitch_release_latency", release_edge - (r0 + 4), 6);
    checkOutput("glitch_press_count", press_count, 0);

    // Reset while pressed and held: press must be treated as new afterwards.
    applyStimulus(1, 8);
    doReset(2);
    clearTally();
    e0 = edge_num + 1;
    applyStimulus(1, 8);
    checkOutput("post_reset_press_latency", press_edge - e0, 6);

    // Reset in the middle of the press debounce wait.
    applyStimulus(0, 10);
    clearTally();
    applyStimulus(1, 5);
    checkOutput("abort_no_press_before_reset", press_count, 0);
    doReset(2);
    e0 = edge_num + 1;
    applyStimulus(1, 8);
    checkOutput("abort_press_latency", press_edge - e0, 6);
    checkOutput("abort_press_count", press_count, 1);

    // Randomized segments, mixing bounces, clean presses and long holds.
    lvl = 1'b0;
    for (int seg = 0; seg < 40; seg++) begin
      lvl = ~lvl;
      if (seg == 21) doReset(1);
      if (seg % 5 == 4) applyStimulus(lvl, $urandom_range(12, 18));
      else applyStimulus(lvl, $urandom_range(1, 7));
    end
    applyStimulus(0, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
